// File: rtl/ogege_video_pkg.sv
// ogege_video_pkg: shared 640x480@60 timing defaults and pixel/line replication encoding.
package ogege_video_pkg;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   typedef enum logic [1:0] {
      SCALE_X1  = 2'b00,
      SCALE_X2  = 2'b01,
      SCALE_X4  = 2'b10,
      SCALE_RSV = 2'b11
   } scale_e;

   // The reserved code falls back to x1.
   function automatic logic [2:0] scale_rep(input logic [1:0] code);
      return code == SCALE_X2 ? 3'd2 : code == SCALE_X4 ? 3'd4 : 3'd1;
   endfunction
endpackage

// File: rtl/scan_timing_gen_if.sv
// scan_timing_gen_if: pixel strobe, replication controls and aligned scan outputs.
interface scan_timing_gen_if #(
   parameter int HSZ    = 10,
   parameter int VSZ    = 10,
   parameter int COL_SZ = 7,
   parameter int ROW_SZ = 6,
   parameter int FC_SZ  = 8
);
   logic              i_pix_en;
   logic [1:0]        i_scale_x;
   logic [1:0]        i_scale_y;
   logic [HSZ-1:0]    o_hcount;
   logic [VSZ-1:0]    o_vcount;
   logic              o_de;
   logic              o_hsync;
   logic              o_vsync;
   logic [3:0]        o_glyph_col;
   logic [3:0]        o_glyph_row;
   logic [COL_SZ-1:0] o_text_col;
   logic [ROW_SZ-1:0] o_text_row;
   logic              o_line_start;
   logic              o_frame_start;
   logic [FC_SZ-1:0]  o_frame_count;

   modport master (
      input  i_pix_en, i_scale_x, i_scale_y,
      output o_hcount, o_vcount, o_de, o_hsync, o_vsync, o_glyph_col, o_glyph_row,
             o_text_col, o_text_row, o_line_start, o_frame_start, o_frame_count
   );

   modport slave (
      output i_pix_en, i_scale_x, i_scale_y,
      input  o_hcount, o_vcount, o_de, o_hsync, o_vsync, o_glyph_col, o_glyph_row,
             o_text_col, o_text_row, o_line_start, o_frame_start, o_frame_count
   );
endinterface

// File: rtl/scan_axis_counter.sv
// scan_axis_counter: one scan axis - position, sync decode, replication, glyph and text counters.
module scan_axis_counter #(
   parameter int CSZ    = 10,
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48,
   parameter int CELL   = 8,
   parameter int TSZ    = 7,
   parameter bit POL    = 1'b0
) (
   input  logic           clk_i,
   input  logic           rstn_i,
   input  logic           step,
   input  logic [2:0]     rep,
   output logic [CSZ-1:0] count,
   output logic           act_nxt,
   output logic           sync,
   output logic           wrap,
   output logic [3:0]     glyph,
   output logic [TSZ-1:0] text
);
   localparam int TOTAL = ACTIVE + FP + SYNC + BP;
   localparam logic [CSZ:0]   A_END = (CSZ+1)'(ACTIVE);
   localparam logic [CSZ:0]   S_BEG = (CSZ+1)'(ACTIVE + FP);
   localparam logic [CSZ:0]   S_END = (CSZ+1)'(ACTIVE + FP + SYNC);
   localparam logic [CSZ-1:0] LAST  = CSZ'(TOTAL - 1);
   localparam logic [3:0]     G_LAST = 4'(CELL - 1);

   logic [CSZ-1:0] nxt;
   logic [2:0]     rx;
   logic           rx_wrap;
   logic           in_sync;

   // Decode is done on the next position so every flop describes the same pixel.
   always_comb begin
      wrap    = step && count == LAST;
      nxt     = wrap ? '0 : count + CSZ'(step);
      act_nxt = {1'b0, nxt} < A_END;
      in_sync = {1'b0, nxt} >= S_BEG && {1'b0, nxt} < S_END;
      rx_wrap = rx == rep - 3'd1;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         count <= LAST;
         sync  <= ~POL;
         rx    <= '0;
         glyph <= '0;
         text  <= '0;
      end else if (step) begin
         count <= nxt;
         sync  <= in_sync ? POL : ~POL;
         if (wrap) begin
            rx    <= '0;
            glyph <= '0;
            text  <= '0;
         end else if (act_nxt) begin
            rx <= rx_wrap ? '0 : rx + 3'd1;
            if (rx_wrap) begin
               glyph <= glyph == G_LAST ? '0 : glyph + 4'd1;
               if (glyph == G_LAST) text <= text + TSZ'(1);
            end
         end
      end
   end
endmodule

// File: rtl/scan_timing_gen.sv
// scan_timing_gen: programmable raster timing with character-cell coordinates and 1x/2x/4x replication,
// all outputs registered and aligned to the pixel on o_hcount/o_vcount.
module scan_timing_gen
   import ogege_video_pkg::*;
#(
   parameter int HSZ      = 10,
   parameter int VSZ      = 10,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CELL_W   = 8,
   parameter int CELL_H   = 8,
   parameter int COL_SZ   = 7,
   parameter int ROW_SZ   = 6,
   parameter int FC_SZ    = 8
) (
   input  logic clk_i,
   input  logic rstn_i,
   scan_timing_gen_if.master vif
);
   if (H_ACTIVE + H_FP + H_SYNC + H_BP > 2 ** HSZ) begin : g_h_range
      $error("scan_timing_gen: H_TOTAL does not fit in HSZ bits");
   end
   if (V_ACTIVE + V_FP + V_SYNC + V_BP > 2 ** VSZ) begin : g_v_range
      $error("scan_timing_gen: V_TOTAL does not fit in VSZ bits");
   end

   logic [2:0] rep_x, rep_y;
   logic       h_wrap, v_wrap, h_act_nxt, v_act_nxt;

   scan_axis_counter #(
      .CSZ(HSZ), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
      .CELL(CELL_W), .TSZ(COL_SZ), .POL(HS_POL)
   ) u_h (
      .clk_i(clk_i), .rstn_i(rstn_i), .step(vif.i_pix_en), .rep(rep_x),
      .count(vif.o_hcount), .act_nxt(h_act_nxt), .sync(vif.o_hsync), .wrap(h_wrap),
      .glyph(vif.o_glyph_col), .text(vif.o_text_col)
   );

   // The vertical axis steps once per line, on the horizontal wrap.
   scan_axis_counter #(
      .CSZ(VSZ), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
      .CELL(CELL_H), .TSZ(ROW_SZ), .POL(VS_POL)
   ) u_v (
      .clk_i(clk_i), .rstn_i(rstn_i), .step(h_wrap), .rep(rep_y),
      .count(vif.o_vcount), .act_nxt(v_act_nxt), .sync(vif.o_vsync), .wrap(v_wrap),
      .glyph(vif.o_glyph_row), .text(vif.o_text_row)
   );

   // Scales are taken at frame entry; the axis counters clear on that same step.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rep_x             <= 3'd1;
         rep_y             <= 3'd1;
         vif.o_de          <= 1'b0;
         vif.o_line_start  <= 1'b0;
         vif.o_frame_start <= 1'b0;
         vif.o_frame_count <= '0;
      end else begin
         vif.o_de          <= h_act_nxt && v_act_nxt;
         vif.o_line_start  <= h_wrap;
         vif.o_frame_start <= v_wrap;
         if (v_wrap) begin
            rep_x             <= scale_rep(vif.i_scale_x);
            rep_y             <= scale_rep(vif.i_scale_y);
            vif.o_frame_count <= vif.o_frame_count + FC_SZ'(1);
         end
      end
   end
endmodule

// File: tb/tb_scan_timing_gen.sv
// tb_scan_timing_gen: directed vector table plus hand sequences for scan_timing_gen.
module tb_scan_timing_gen;
   logic       clk_100mhz = 1'b0;
   logic       rstn_i     = 1'b0;
   logic       pix_en     = 1'b0;
   logic [1:0] sx         = 2'b00;
   logic [1:0] sy         = 2'b00;
   int         n_cmp      = 0;
   int         n_bad      = 0;
   int         ls6_cnt    = 0;

   always #5 clk_100mhz = ~clk_100mhz;

   // Default horizontal timing, short vertical frame (7 lines) to keep runs brief.
   scan_timing_gen_if #(.HSZ(10), .VSZ(10)) if_a ();
   scan_timing_gen_if #(.HSZ(10), .VSZ(10)) if_6 ();
   scan_timing_gen_if #(.HSZ(4), .VSZ(3)) if_t ();

   assign if_a.i_pix_en = pix_en;
   assign if_a.i_scale_x = sx;
   assign if_a.i_scale_y = sy;
   assign if_6.i_pix_en = pix_en;
   assign if_6.i_scale_x = sx;
   assign if_6.i_scale_y = sy;
   assign if_t.i_pix_en = pix_en;
   assign if_t.i_scale_x = sx;
   assign if_t.i_scale_y = sy;

   scan_timing_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut (
      .clk_i(clk_100mhz), .rstn_i(rstn_i), .vif(if_a)
   );
   scan_timing_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .CELL_W(6)) dut6 (
      .clk_i(clk_100mhz), .rstn_i(rstn_i), .vif(if_6)
   );
   scan_timing_gen #(.HSZ(4), .VSZ(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut_t (
      .clk_i(clk_100mhz), .rstn_i(rstn_i), .vif(if_t)
   );

   always @(negedge clk_100mhz) if (if_6.o_line_start) ls6_cnt <= ls6_cnt + 1;

   typedef struct {
      int k;
      int h, v, de, hs, vs, gc, tc, gr, tr, ls, fs, fc;
   } vec_t;

   vec_t vec[14];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Starts and ends on a falling edge; outputs are stable there.
   task automatic step_n(input int n);
      pix_en = 1'b1;
      repeat (n) @(negedge clk_100mhz);
      pix_en = 1'b0;
   endtask

   task automatic chk_pos(input string name, input int h, input int v);
      chk({name, ".h"}, int'(if_a.o_hcount), h);
      chk({name, ".v"}, int'(if_a.o_vcount), v);
   endtask

   initial begin
      int done;
      vec[0]  = '{1,    0,   0, 1, 1, 1, 0, 0,  0, 0, 1, 1, 1};
      vec[1]  = '{2,    1,   0, 1, 1, 1, 1, 0,  0, 0, 0, 0, 1};
      vec[2]  = '{9,    8,   0, 1, 1, 1, 0, 1,  0, 0, 0, 0, 1};
      vec[3]  = '{640,  639, 0, 1, 1, 1, 7, 79, 0, 0, 0, 0, 1};
      vec[4]  = '{641,  640, 0, 0, 1, 1, 7, 79, 0, 0, 0, 0, 1};
      vec[5]  = '{656,  655, 0, 0, 1, 1, 7, 79, 0, 0, 0, 0, 1};
      vec[6]  = '{657,  656, 0, 0, 0, 1, 7, 79, 0, 0, 0, 0, 1};
      vec[7]  = '{752,  751, 0, 0, 0, 1, 7, 79, 0, 0, 0, 0, 1};
      vec[8]  = '{753,  752, 0, 0, 1, 1, 7, 79, 0, 0, 0, 0, 1};
      vec[9]  = '{801,  0,   1, 1, 1, 1, 0, 0,  1, 0, 1, 0, 1};
      vec[10] = '{3201, 0,   4, 0, 1, 1, 0, 0,  3, 0, 1, 0, 1};
      vec[11] = '{4001, 0,   5, 0, 1, 0, 0, 0,  3, 0, 1, 0, 1};
      vec[12] = '{4801, 0,   6, 0, 1, 1, 0, 0,  3, 0, 1, 0, 1};
      vec[13] = '{5601, 0,   0, 1, 1, 1, 0, 0,  0, 0, 1, 1, 2};

      repeat (3) @(negedge clk_100mhz);
      chk_pos("rst", 799, 6);
      chk("rst.de", int'(if_a.o_de), 0);
      chk("rst.hs", int'(if_a.o_hsync), 1);
      chk("rst.vs", int'(if_a.o_vsync), 1);
      chk("rst.fc", int'(if_a.o_frame_count), 0);
      rstn_i = 1'b1;
      @(negedge clk_100mhz);
      chk("held.h", int'(if_a.o_hcount), 799);

      done = 0;
      foreach (vec[i]) begin
         step_n(vec[i].k - done);
         done = vec[i].k;
         chk_pos($sformatf("v%0d", i), vec[i].h, vec[i].v);
         chk($sformatf("v%0d.de", i), int'(if_a.o_de), vec[i].de);
         chk($sformatf("v%0d.hs", i), int'(if_a.o_hsync), vec[i].hs);
         chk($sformatf("v%0d.vs", i), int'(if_a.o_vsync), vec[i].vs);
         chk($sformatf("v%0d.gc", i), int'(if_a.o_glyph_col), vec[i].gc);
         chk($sformatf("v%0d.tc", i), int'(if_a.o_text_col), vec[i].tc);
         chk($sformatf("v%0d.gr", i), int'(if_a.o_glyph_row), vec[i].gr);
         chk($sformatf("v%0d.tr", i), int'(if_a.o_text_row), vec[i].tr);
         chk($sformatf("v%0d.ls", i), int'(if_a.o_line_start), vec[i].ls);
         chk($sformatf("v%0d.fs", i), int'(if_a.o_frame_start), vec[i].fs);
         chk($sformatf("v%0d.fc", i), int'(if_a.o_frame_count), vec[i].fc);
         if (vec[i].k == 640) begin
            chk("cw6.gc", int'(if_6.o_glyph_col), 3);
            chk("cw6.tc", int'(if_6.o_text_col), 106);
         end
      end

      // Freeze: pulses drop after one clk, everything else holds.
      @(negedge clk_100mhz);
      chk("frz.ls", int'(if_a.o_line_start), 0);
      chk("frz.fs", int'(if_a.o_frame_start), 0);
      chk("cw6.ls_count", ls6_cnt, 8);
      repeat (99) @(negedge clk_100mhz);
      chk_pos("frz", 0, 0);
      chk("frz.de", int'(if_a.o_de), 1);
      chk("frz.fc", int'(if_a.o_frame_count), 2);

      for (int i = 1; i <= 8; i++) begin
         step_n(1);
         chk($sformatf("tog%0d.h", i), int'(if_a.o_hcount), i);
         repeat (3) @(negedge clk_100mhz);
         chk($sformatf("tog%0d.hold", i), int'(if_a.o_hcount), i);
         chk($sformatf("tog%0d.ls", i), int'(if_a.o_line_start), 0);
      end
      step_n(791);
      chk_pos("pre_wrap", 799, 0);
      step_n(1);
      chk("wrap.ls", int'(if_a.o_line_start), 1);
      chk_pos("wrap", 0, 1);
      @(negedge clk_100mhz);
      chk("wrap.ls_drop", int'(if_a.o_line_start), 0);

      // Mid-frame scale change must wait for the next frame entry.
      sx = 2'b01;
      sy = 2'b01;
      step_n(639);
      chk_pos("mid", 639, 1);
      chk("mid.gc", int'(if_a.o_glyph_col), 7);
      chk("mid.tc", int'(if_a.o_text_col), 79);
      chk("mid.gr", int'(if_a.o_glyph_row), 1);
      step_n(4161);
      chk_pos("nf", 0, 0);
      chk("nf.fs", int'(if_a.o_frame_start), 1);
      chk("nf.fc", int'(if_a.o_frame_count), 3);
      step_n(1);
      chk("x2.h1.gc", int'(if_a.o_glyph_col), 0);
      step_n(1);
      chk("x2.h2.gc", int'(if_a.o_glyph_col), 1);
      step_n(637);
      chk_pos("x2.end", 639, 0);
      chk("x2.gc", int'(if_a.o_glyph_col), 7);
      chk("x2.tc", int'(if_a.o_text_col), 39);
      step_n(961);
      chk_pos("y2", 0, 2);
      chk("y2.gr", int'(if_a.o_glyph_row), 1);
      chk("y2.tr", int'(if_a.o_text_row), 0);

      // Asynchronous reset mid-frame, between clock edges.
      step_n(1100);
      chk_pos("pre_rst", 300, 3);
      chk("pre_rst.de", int'(if_a.o_de), 1);
      #2 rstn_i = 1'b0;
      #1;
      chk_pos("arst", 799, 6);
      chk("arst.de", int'(if_a.o_de), 0);
      chk("arst.hs", int'(if_a.o_hsync), 1);
      chk("arst.vs", int'(if_a.o_vsync), 1);
      chk("arst.gc", int'(if_a.o_glyph_col), 0);
      chk("arst.tc", int'(if_a.o_text_col), 0);
      chk("arst.gr", int'(if_a.o_glyph_row), 0);
      chk("arst.fc", int'(if_a.o_frame_count), 0);
      @(negedge clk_100mhz);
      sx = 2'b00;
      sy = 2'b00;
      rstn_i = 1'b1;

      // Frame counter wrap on the small-timing instance (98 pixels per frame).
      step_n(1);
      chk("fcw.fc1", int'(if_t.o_frame_count), 1);
      chk("fcw.h0", int'(if_t.o_hcount), 0);
      step_n(254 * 98);
      chk("fcw.fc255", int'(if_t.o_frame_count), 255);
      step_n(98);
      chk("fcw.fc0", int'(if_t.o_frame_count), 0);
      chk("fcw.fs", int'(if_t.o_frame_start), 1);
      chk("fcw.v0", int'(if_t.o_vcount), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
